// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot scan decoder: mode encodings,
// controller state encoding and the index-to-one-hot function.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest output vector the onehot() helper can produce.
  localparam int ONEHOT_MAX = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Bit idx set when idx addresses one of the first n_out lines, else all zero.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n_out);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < ONEHOT_MAX; i++) begin
      v[i[7:0]] = (i == idx) && (i < n_out);
    end
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the scan sequencer: counts cycles spent on one index and
// flags the cycle in which the count matches the programmed dwell.
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt_p1;

  // Compared against the live dwell value, so a shortened dwell lets the
  // count run through its full range before matching again.
  assign tick = (cnt_p1 == dwell);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (run) begin
      cnt_p1 <= tick ? '0 : cnt_p1 + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-N_OUT one-hot decoder with enable, a handshaked direct
// select mode and an auto-scan mode with programmable dwell per index.
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int N_OUT      = 8,
  parameter int DWELL_W    = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N_OUT{1'b1}}
                                                            : {N_OUT{1'b0}};

  state_t           state_p1;
  state_t           state_nx;
  logic [SEL_W-1:0] idx_p1;
  logic [SEL_W-1:0] idx_nx;
  logic [SEL_W-1:0] idx_acc;
  logic [N_OUT-1:0] out_p1;
  logic [N_OUT-1:0] out_nx;
  logic [N_OUT-1:0] dec;
  logic             wrap_p1;
  logic             wrap_nx;
  logic             xfer;
  logic             enter_scan;
  logic             stay_scan;
  logic             tmr_clr;
  logic             tmr_run;
  logic             tmr_tick;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .run   (tmr_run),
    .dwell (dwell),
    .tick  (tmr_tick)
  );

  // Stage p1: controller state, decoded index, output word and wrap strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      idx_p1   <= '0;
      out_p1   <= INACTIVE;
      wrap_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      idx_p1   <= idx_nx;
      out_p1   <= out_nx;
      wrap_p1  <= wrap_nx;
    end
  end

  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      IDLE: begin
        if (ena) begin
          state_nx = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
      end
      DIRECT: begin
        if (!ena) begin
          state_nx = IDLE;
        end else if (mode == MODE_SCAN) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (!ena) begin
          state_nx = IDLE;
        end else if (mode == MODE_DIRECT) begin
          state_nx = DIRECT;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A select offered while still in DIRECT is taken even if the mode flips.
    xfer       = (state_p1 == DIRECT) && sel_valid;
    enter_scan = (state_nx == SCAN) && (state_p1 != SCAN);
    stay_scan  = (state_nx == SCAN) && (state_p1 == SCAN);
    idx_acc    = xfer ? sel : idx_p1;

    idx_nx  = idx_acc;
    wrap_nx = 1'b0;
    if (enter_scan) begin
      if (idx_acc > LAST_IDX) begin
        idx_nx = '0;
      end
    end else if (stay_scan && tmr_tick) begin
      if (idx_p1 >= LAST_IDX) begin
        idx_nx  = '0;
        wrap_nx = 1'b1;
      end else begin
        idx_nx = idx_p1 + SEL_W'(1);
      end
    end

    tmr_run = stay_scan;
    tmr_clr = enter_scan || (state_nx == DIRECT);

    // Decode from the index being registered so out and idx never disagree.
    dec    = N_OUT'(onehot(32'(idx_nx), N_OUT));
    out_nx = '0;
    if ((state_nx != IDLE) && (idx_nx <= LAST_IDX)) begin
      out_nx = dec;
    end
    out_nx = out_nx ^ INACTIVE;
  end

  assign sel_ready = (state_p1 == DIRECT);
  assign idx       = idx_p1;
  assign out       = out_p1;
  assign wrap      = wrap_p1;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Randomised and directed bench for onehot_scan_decoder: three instances
// (N_OUT=8, N_OUT=6, ACTIVE_LOW=1) share stimulus and are checked each cycle.
module tb_onehot_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel = '0;
  logic        sel_valid = 1'b0;
  logic [15:0] dwell = '0;

  logic [7:0] out8, outlo;
  logic [5:0] out6;
  logic [2:0] idx8, idx6, idxlo;
  logic       wrap8, wrap6, wraplo;
  logic       rdy8, rdy6, rdylo;

  logic [31:0] g_out[3];
  logic [31:0] g_idx[3];
  logic [31:0] g_wrap[3];
  logic [31:0] g_rdy[3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int cfg_n[3]   = '{8, 6, 8};
  int cfg_low[3] = '{0, 0, 1};
  int m_state[3];   // 0 idle, 1 direct, 2 scan
  int m_idx[3];
  int m_cnt[3];
  int m_wrap[3];
  int m_out[3];

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(3), .N_OUT(8), .DWELL_W(16), .ACTIVE_LOW(0)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy8), .dwell(dwell), .out(out8), .idx(idx8), .wrap(wrap8));

  onehot_scan_decoder #(.SEL_W(3), .N_OUT(6), .DWELL_W(16), .ACTIVE_LOW(0)) u_dut6 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy6), .dwell(dwell), .out(out6), .idx(idx6), .wrap(wrap6));

  onehot_scan_decoder #(.SEL_W(3), .N_OUT(8), .DWELL_W(16), .ACTIVE_LOW(1)) u_dutlo (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdylo), .dwell(dwell), .out(outlo), .idx(idxlo), .wrap(wraplo));

  assign g_out[0]  = {24'b0, out8};
  assign g_out[1]  = {26'b0, out6};
  assign g_out[2]  = {24'b0, outlo};
  assign g_idx[0]  = {29'b0, idx8};
  assign g_idx[1]  = {29'b0, idx6};
  assign g_idx[2]  = {29'b0, idxlo};
  assign g_wrap[0] = {31'b0, wrap8};
  assign g_wrap[1] = {31'b0, wrap6};
  assign g_wrap[2] = {31'b0, wraplo};
  assign g_rdy[0]  = {31'b0, rdy8};
  assign g_rdy[1]  = {31'b0, rdy6};
  assign g_rdy[2]  = {31'b0, rdylo};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference behaviour per clock edge, written from the decoder's rules.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int ns;
      int nidx;
      int mask;
      mask = (1 << cfg_n[k]) - 1;
      if (rst) begin
        m_state[k] = 0;
        m_idx[k]   = 0;
        m_cnt[k]   = 0;
        m_wrap[k]  = 0;
        m_out[k]   = (cfg_low[k] != 0) ? mask : 0;
      end else begin
        ns = !ena ? 0 : (mode ? 2 : 1);
        nidx = m_idx[k];
        m_wrap[k] = 0;
        if (m_state[k] == 1 && sel_valid) nidx = int'(sel);
        if (ns == 2 && m_state[k] != 2) begin
          m_cnt[k] = 0;
          if (nidx >= cfg_n[k]) nidx = 0;
        end else if (ns == 2) begin
          if (m_cnt[k] == int'(dwell)) begin
            m_cnt[k] = 0;
            if (m_idx[k] >= cfg_n[k] - 1) begin
              nidx = 0;
              m_wrap[k] = 1;
            end else begin
              nidx = m_idx[k] + 1;
            end
          end else begin
            m_cnt[k] = (m_cnt[k] + 1) % 65536;
          end
        end else if (ns == 1) begin
          m_cnt[k] = 0;
        end
        m_idx[k]   = nidx;
        m_state[k] = ns;
        m_out[k]   = (ns != 0 && nidx < cfg_n[k]) ? (1 << nidx) : 0;
        if (cfg_low[k] != 0) m_out[k] = m_out[k] ^ mask;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.out", k),  g_out[k],  32'(m_out[k]));
      chk($sformatf("u%0d.idx", k),  g_idx[k],  32'(m_idx[k]));
      chk($sformatf("u%0d.wrap", k), g_wrap[k], 32'(m_wrap[k]));
      chk($sformatf("u%0d.rdy", k),  g_rdy[k],  (m_state[k] == 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wraps;
    // Reset
    rst = 1'b1;
    step();
    step();
    chk("rst_out_lo", g_out[2], 32'hFF);
    chk("rst_out8", g_out[0], 32'h00);
    chk("rst_rdy", g_rdy[0], 32'd0);

    // Direct select of 5
    rst = 1'b0; ena = 1'b1; mode = 1'b0; sel = 3'd5; sel_valid = 1'b1;
    step();
    chk("direct_rdy", g_rdy[0], 32'd1);
    step();
    chk("sel5_idx", g_idx[0], 32'd5);
    chk("sel5_out", g_out[0], 32'h20);
    chk("sel5_out_lo", g_out[2], 32'hDF);

    // Hold without valid while sel toggles
    sel_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = 3'(i);
      step();
    end
    chk("hold_out", g_out[0], 32'h20);

    // Scan with dwell 2
    dwell = 16'd2; mode = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // Scan with dwell 0, freeze with ena low at index 3
    mode = 1'b0;
    step();
    dwell = 16'd0; mode = 1'b1;
    step();
    for (int i = 0; i < 30 && m_idx[1] != 3; i++) step();
    chk("reach_idx3", g_idx[1], 32'd3);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("frozen_out6", g_out[1], 32'h0);
    chk("frozen_idx6", g_idx[1], 32'd3);
    ena = 1'b1;
    step();
    chk("resume_out6", g_out[1], 32'h08);
    step();
    chk("resume_idx6", g_idx[1], 32'd4);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wrap6) wraps++;
    end
    chk("wrap_count6", 32'(wraps), 32'd2);

    // Out-of-range direct select then scan entry
    mode = 1'b0; sel = 3'd7; sel_valid = 1'b1;
    step();
    step();
    chk("oor_idx6", g_idx[1], 32'd7);
    chk("oor_out6", g_out[1], 32'h0);
    sel_valid = 1'b0; mode = 1'b1;
    step();
    chk("oor_scan_idx6", g_idx[1], 32'd0);
    chk("oor_scan_wrap6", g_wrap[1], 32'd0);
    chk("oor_scan_out6", g_out[1], 32'h01);
    for (int i = 0; i < 8; i++) step();

    // Active-low direct select, then reset mid-scan
    mode = 1'b0; sel = 3'd2; sel_valid = 1'b1;
    step();
    step();
    chk("lo_sel2_out", g_out[2], 32'hFB);
    sel_valid = 1'b0; mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_out_lo", g_out[2], 32'hFF);
    chk("midrst_idx_lo", g_idx[2], 32'd0);
    chk("midrst_wrap_lo", g_wrap[2], 32'd0);
    chk("midrst_rdy_lo", g_rdy[2], 32'd0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
      sel_valid = 1'($urandom_range(0, 1));
      if (mode == 1'b0) dwell = 16'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
